pwm_bank: RTL and testbench

//   PCA9685-style 12-bit PWM engine downstream of the I2C target. Consumes its byte-wide

---
 rtl/pwm_bank.sv | 159 +++++++++++++++
 tb/tb_pwm_bank.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_bank.sv
// pwm_bank: shared-phase 12-bit PWM engine with shadow registers applied at phase wrap.
// Define PWM_BANK_READBACK_EN to add a registered readback port; otherwise rd_data_o is 0.
module pwm_bank #(
    parameter int unsigned CHANNELS     = 4,
    parameter logic [7:0]  PRESCALE_RST = 8'd30
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                wr_en_i,
    input  logic [7:0]          wr_addr_i,
    input  logic [7:0]          wr_data_i,
    input  logic [7:0]          rd_addr_i,
    output logic [7:0]          rd_data_o,
    output logic                cycle_start_o,
    output logic [CHANNELS-1:0] pwm_o
);
    // Slot layout: bit 12 = FULL_ON / FULL_OFF flag, bits 11:0 = edge position.
    localparam logic [12:0] SLOT_RST_ON  = 13'h0000;
    localparam logic [12:0] SLOT_RST_OFF = 13'h1000;

    logic [7:0]          mode1_q, mode1_d;
    logic [7:0]          prescale_q, prescale_d;
    logic [7:0]          presc_q, presc_d;
    logic [11:0]         phase_q, phase_d;
    logic                cycle_start_q, cycle_start_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [12:0]         sh_on_q   [CHANNELS];
    logic [12:0]         sh_on_d   [CHANNELS];
    logic [12:0]         sh_off_q  [CHANNELS];
    logic [12:0]         sh_off_d  [CHANNELS];
    logic [12:0]         act_on_q  [CHANNELS];
    logic [12:0]         act_on_d  [CHANNELS];
    logic [12:0]         act_off_q [CHANNELS];
    logic [12:0]         act_off_d [CHANNELS];
    logic                sleep;

    function automatic logic [7:0] chan_addr(input int n, input int k);
        return 8'(6 + 4 * n + k);
    endfunction

    assign sleep = mode1_q[4];

    always_comb begin
        mode1_d    = mode1_q;
        prescale_d = prescale_q;
        sh_on_d    = sh_on_q;
        sh_off_d   = sh_off_q;
        if (wr_en_i) begin
            if (wr_addr_i == 8'h00) mode1_d = wr_data_i;
            if (wr_addr_i == 8'hFE && sleep) prescale_d = wr_data_i;
            for (int n = 0; n < CHANNELS; n++) begin
                if (wr_addr_i == chan_addr(n, 0)) sh_on_d[n][7:0]   = wr_data_i;
                if (wr_addr_i == chan_addr(n, 1)) sh_on_d[n][12:8]  = wr_data_i[4:0];
                if (wr_addr_i == chan_addr(n, 2)) sh_off_d[n][7:0]  = wr_data_i;
                if (wr_addr_i == chan_addr(n, 3)) sh_off_d[n][12:8] = wr_data_i[4:0];
            end
        end
    end

    // Active copy takes the _d shadow so a write landing on the wrap tick is included.
    always_comb begin
        presc_d       = presc_q;
        phase_d       = phase_q;
        cycle_start_d = 1'b0;
        act_on_d      = act_on_q;
        act_off_d     = act_off_q;
        if (sleep) begin
            presc_d   = '0;
            phase_d   = '0;
            act_on_d  = sh_on_d;
            act_off_d = sh_off_d;
        end else if (presc_q == prescale_q) begin
            presc_d = '0;
            phase_d = phase_q + 12'd1;
            if (phase_q == 12'hFFF) begin
                cycle_start_d = 1'b1;
                act_on_d      = sh_on_d;
                act_off_d     = sh_off_d;
            end
        end else begin
            presc_d = presc_q + 8'd1;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (sleep || act_off_q[n][12]) begin
                pwm_d[n] = 1'b0;
            end else if (act_on_q[n][12]) begin
                pwm_d[n] = 1'b1;
            end else if (act_on_q[n][11:0] < act_off_q[n][11:0]) begin
                pwm_d[n] = (phase_q >= act_on_q[n][11:0]) && (phase_q < act_off_q[n][11:0]);
            end else if (act_on_q[n][11:0] > act_off_q[n][11:0]) begin
                pwm_d[n] = (phase_q >= act_on_q[n][11:0]) || (phase_q < act_off_q[n][11:0]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mode1_q       <= 8'h10;
            prescale_q    <= PRESCALE_RST;
            presc_q       <= '0;
            phase_q       <= '0;
            cycle_start_q <= 1'b0;
            pwm_q         <= '0;
            for (int n = 0; n < CHANNELS; n++) begin
                sh_on_q[n]   <= SLOT_RST_ON;
                sh_off_q[n]  <= SLOT_RST_OFF;
                act_on_q[n]  <= SLOT_RST_ON;
                act_off_q[n] <= SLOT_RST_OFF;
            end
        end else begin
            mode1_q       <= mode1_d;
            prescale_q    <= prescale_d;
            presc_q       <= presc_d;
            phase_q       <= phase_d;
            cycle_start_q <= cycle_start_d;
            pwm_q         <= pwm_d;
            sh_on_q       <= sh_on_d;
            sh_off_q      <= sh_off_d;
            act_on_q      <= act_on_d;
            act_off_q     <= act_off_d;
        end
    end

    assign cycle_start_o = cycle_start_q;
    assign pwm_o         = pwm_q;

`ifdef PWM_BANK_READBACK_EN
    logic [7:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_data_d = 8'h00;
        if (rd_addr_i == 8'h00) rd_data_d = mode1_q;
        if (rd_addr_i == 8'hFE) rd_data_d = prescale_q;
        for (int n = 0; n < CHANNELS; n++) begin
            if (rd_addr_i == chan_addr(n, 0)) rd_data_d = sh_on_q[n][7:0];
            if (rd_addr_i == chan_addr(n, 1)) rd_data_d = {3'b000, sh_on_q[n][12:8]};
            if (rd_addr_i == chan_addr(n, 2)) rd_data_d = sh_off_q[n][7:0];
            if (rd_addr_i == chan_addr(n, 3)) rd_data_d = {3'b000, sh_off_q[n][12:8]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) rd_data_q <= 8'h00;
        else         rd_data_q <= rd_data_d;
    end

    assign rd_data_o = rd_data_q;
`else
    // MODE1 store-only bits and rd_addr_i only matter when readback exists.
    logic unused_rd;
    assign unused_rd = ^{rd_addr_i, mode1_q[7:5], mode1_q[3:0]};
    assign rd_data_o = 8'h00;
`endif

endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: randomized and directed stimulus for pwm_bank, checked each cycle against a
// register-image model that derives phase from elapsed awake cycles.
module tb_pwm_bank;
    localparam int         CH   = 4;
    localparam logic [7:0] PRST = 8'd0;

    logic          clk_i     = 1'b0;
    logic          rst_ni    = 1'b0;
    logic          wr_en_i   = 1'b0;
    logic [7:0]    wr_addr_i = 8'h00;
    logic [7:0]    wr_data_i = 8'h00;
    logic [7:0]    rd_addr_i = 8'h00;
    logic [7:0]    rd_data_o;
    logic          cycle_start_o;
    logic [CH-1:0] pwm_o;

    pwm_bank #(.CHANNELS(CH), .PRESCALE_RST(PRST)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_en_i       (wr_en_i),
        .wr_addr_i     (wr_addr_i),
        .wr_data_i     (wr_data_i),
        .rd_addr_i     (rd_addr_i),
        .rd_data_o     (rd_data_o),
        .cycle_start_o (cycle_start_o),
        .pwm_o         (pwm_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;
    int hi [CH];

    // Model: byte image of the register map (as readback would see it) and active copies.
    logic [7:0]    mreg [256];
    logic [7:0]    act  [CH][4];
    int            run_cnt;
    logic [CH-1:0] m_pwm;
    logic          m_cs;
    logic [7:0]    m_rd;

    function automatic bit chan_slot(input logic [7:0] a, output int ch, output int k);
        int off;
        off = int'(a) - 6;
        ch  = off / 4;
        k   = off % 4;
        return (off >= 0) && (ch < CH);
    endfunction

    task automatic load_active();
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < 4; k++)
                act[c][k] = mreg[6 + 4 * c + k];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mreg[i] = 8'h00;
        mreg[0]     = 8'h10;
        mreg[8'hFE] = PRST;
        for (int c = 0; c < CH; c++) mreg[6 + 4 * c + 3] = 8'h10;
        load_active();
        run_cnt = 0;
    endtask

    // High when the phase lies within the (circular) window starting at ON of length OFF-ON.
    function automatic bit model_bit(input int c, input int ph);
        int on, off;
        on  = int'({act[c][1][3:0], act[c][0]});
        off = int'({act[c][3][3:0], act[c][2]});
        if (act[c][3][4]) return 1'b0;
        if (act[c][1][4]) return 1'b1;
        return ((ph - on + 4096) % 4096) < ((off - on + 4096) % 4096);
    endfunction

    always @(posedge clk_i) begin : model_step
        int ch, k, p, ph;
        bit sleep, wrap;
        if (!rst_ni) begin
            model_reset();
            m_pwm = '0;
            m_cs  = 1'b0;
            m_rd  = 8'h00;
        end else begin
            sleep = mreg[0][4];
            p     = int'(mreg[8'hFE]);
            ph    = (run_cnt / (p + 1)) % 4096;
            for (int c = 0; c < CH; c++) m_pwm[c] = !sleep && model_bit(c, ph);
`ifdef PWM_BANK_READBACK_EN
            m_rd = mreg[rd_addr_i];
`else
            m_rd = 8'h00;
`endif
            if (wr_en_i) begin
                if (wr_addr_i == 8'h00) begin
                    mreg[0] = wr_data_i;
                end else if (wr_addr_i == 8'hFE) begin
                    if (sleep) mreg[8'hFE] = wr_data_i;
                end else if (chan_slot(wr_addr_i, ch, k)) begin
                    mreg[wr_addr_i] = (k % 2 == 1) ? (wr_data_i & 8'h1F) : wr_data_i;
                end
            end
            if (sleep) begin
                run_cnt = 0;
                m_cs    = 1'b0;
                load_active();
            end else begin
                wrap = (run_cnt % (p + 1) == p) && (ph == 4095);
                m_cs = wrap;
                if (wrap) load_active();
                run_cnt++;
            end
        end
    end

    always @(negedge clk_i) begin
        cyc++;
        if (chk_en) begin
            checks++;
            if (pwm_o !== m_pwm) begin
                failures++;
                $display("FAIL pwm cyc=%0d got=%b exp=%b", cyc, pwm_o, m_pwm);
            end
            checks++;
            if (cycle_start_o !== m_cs) begin
                failures++;
                $display("FAIL cycle_start cyc=%0d got=%b exp=%b", cyc, cycle_start_o, m_cs);
            end
            checks++;
            if (rd_data_o !== m_rd) begin
                failures++;
                $display("FAIL rd_data cyc=%0d got=%h exp=%h", cyc, rd_data_o, m_rd);
            end
        end
    end

    task automatic check(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a;
        wr_data_i = d;
        @(negedge clk_i);
        wr_en_i = 1'b0;
    endtask

    task automatic wait_cs(input int limit, output int waited);
        waited = 0;
        do begin
            @(negedge clk_i);
            waited++;
        end while (cycle_start_o !== 1'b1 && waited < limit);
        check("cycle_start timeout", int'(cycle_start_o === 1'b1), 1);
    endtask

    // Called at the negedge showing cycle_start_o; samples the 4096 outputs of that frame.
    task automatic count_frame(input int wr_at, input logic [7:0] a, input logic [7:0] d);
        for (int c = 0; c < CH; c++) hi[c] = 0;
        for (int i = 0; i < 4096; i++) begin
            if (i == wr_at) begin
                wr_en_i   = 1'b1;
                wr_addr_i = a;
                wr_data_i = d;
            end else begin
                wr_en_i = 1'b0;
            end
            @(negedge clk_i);
            for (int c = 0; c < CH; c++) hi[c] += int'(pwm_o[c]);
        end
        wr_en_i = 1'b0;
        check("frame period 4096", int'(cycle_start_o === 1'b1), 1);
    endtask

    initial begin
        int w;
        logic [7:0] a, d;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_en = 1'b1;
        check("reset pwm", int'(pwm_o), 0);
        check("reset cycle_start", int'(cycle_start_o), 0);
        check("reset rd_data", int'(rd_data_o), 0);
        rst_ni = 1'b1;

        wr(8'h00, 8'h00);
        wr(8'h06, 8'h00); wr(8'h07, 8'h00); wr(8'h08, 8'h00); wr(8'h09, 8'h08);
        wr(8'h0A, 8'h00); wr(8'h0B, 8'h0F); wr(8'h0C, 8'h00); wr(8'h0D, 8'h01);
        for (int i = 0; i < 4; i++) wr(8'(8'h12 + i), 8'($urandom));
        wr(8'h16, 8'($urandom));
        wait_cs(6000, w);

        count_frame(100, 8'h09, 8'h04);
        check("ch0 50pct frame", hi[0], 2048);
        check("ch1 wrap frame", hi[1], 512);
        check("ch2 full_off frame", hi[2], 0);

        count_frame(50, 8'h0F, 8'h10);
        check("ch0 after midframe edit", hi[0], 1024);
        check("ch1 wrap frame 2", hi[1], 512);

        count_frame(50, 8'h11, 8'h00);
        check("ch2 on+off both set", hi[2], 0);

        count_frame(10, 8'hFE, 8'h03);
        check("ch2 full_on frame", hi[2], 4096);

        count_frame(-1, 8'h00, 8'h00);
        check("ch2 full_on frame 2", hi[2], 4096);
        check("ch0 frame after ignored prescale", hi[0], 1024);

        wr(8'h00, 8'h10);
        wr(8'hFE, 8'h03);
        wr(8'h00, 8'h00);
        wait_cs(20000, w);
        check("first wrap after wake p3", w, 16384);
        wait_cs(20000, w);
        check("prescaled period p3", w, 16384);

        for (int i = 0; i < 3000; i++) begin
            rd_addr_i = 8'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 9))
                    0: begin
                        a = 8'h00;
                        d = 8'($urandom);
                        d[4] = ($urandom_range(0, 7) == 0);
                    end
                    1: begin
                        a = 8'hFE;
                        d = 8'($urandom_range(0, 2));
                    end
                    9: begin
                        a = 8'($urandom);
                        d = 8'($urandom);
                    end
                    default: begin
                        a = 8'($urandom_range(6, 6 + 4 * CH + 3));
                        d = 8'($urandom);
                    end
                endcase
                wr_en_i   = 1'b1;
                wr_addr_i = a;
                wr_data_i = d;
            end else begin
                wr_en_i = 1'b0;
            end
            @(negedge clk_i);
        end
        wr_en_i   = 1'b0;
        rd_addr_i = 8'h00;

        wr(8'h00, 8'h00);
        repeat (300) @(negedge clk_i);
        rst_ni = 1'b0;
        @(negedge clk_i);
        check("pwm after midframe reset", int'(pwm_o), 0);
        check("cycle_start after reset", int'(cycle_start_o), 0);
        rst_ni    = 1'b1;
        rd_addr_i = 8'h09;
        @(negedge clk_i);
`ifdef PWM_BANK_READBACK_EN
        check("readback OFF_H ch0", int'(rd_data_o), 16);
`else
        check("readback tied off", int'(rd_data_o), 0);
`endif
        rd_addr_i = 8'h00;
        @(negedge clk_i);
`ifdef PWM_BANK_READBACK_EN
        check("readback MODE1 after reset", int'(rd_data_o), 16);
`else
        check("readback tied off mode1", int'(rd_data_o), 0);
`endif
        repeat (20) @(negedge clk_i);
        check("pwm held in sleep after reset", int'(pwm_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
